cursor_key_ctrl: RTL and testbench
==================================

// Module: cursor_key_ctrl
// PURPOSE
//  Conditions the four raw DE-board pushbuttons and sequences cursor movement:
//  synchronises, debounces, arbitrates between simultaneous presses and issues
//  one-cycle move pulses with hold-to-repeat. Sits between the board KEY pins
//  and the cursor position register; move[3:0] drives the cursor's KEY input.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000    cycles a key must be stable before its debounced state changes (>=2)
//  REPEAT_DELAY     25000000  cycles from first pulse to first repeat pulse (>=2)
//  REPEAT_RATE      5000000   cycles between subsequent repeat pulses (>=2)
//  REPEAT_EN        1         1 = hold-to-repeat enabled; 0 = one pulse per press
//  CNT_W            25        width of debounce/repeat counters; must hold the largest count
// PORTS
//  clock     in   1  system clock
//  reset     in   1  asynchronous, active-low reset
//  KEY       in   4  raw pushbuttons, active-low (0 = pressed); [3]=left [2]=up [1]=down [0]=right
//  enable    in   1  1 = accept moves; 0 = suppress and abort (e.g. game over)
//  move      out  4  one-hot, one-cycle move pulse, active-high, same bit mapping as KEY
//  key_held  out  4  debounced pressed state per key, active-high
//  busy      out  1  1 while a key owns the repeat FSM (state != IDLE)
// BEHAVIOUR
//  Reset (reset=0, async): move=0, key_held=0, busy=0, sync flops=released, counters=0,
//   fresh flags=0, state=IDLE. Asserting reset mid-repeat drops any pending pulse at once.
//  Sync: 2-flop synchroniser per key, inverted to pressed=1.
//  Debounce, per key: counter clears whenever sync==key_held; while they differ it
//   increments; on the edge where it equals DEBOUNCE_CYCLES-1 with sync still differing,
//   key_held takes the sync value and the counter clears. Glitches shorter than
//   DEBOUNCE_CYCLES cycles never change key_held.
//  Fresh flags: fresh[i] set on a key_held[i] 0->1 edge, cleared on its 1->0 edge; ALL
//   fresh flags clear on any grant and whenever enable=0. Keys pressed while another key
//   owns the FSM are therefore discarded and must be re-pressed.
//  FSM (owner = latched 2-bit key index):
//   IDLE:   if enable and any fresh: grant highest priority fresh key (left>up>down>right),
//           move[owner]=1 for one cycle, -> DELAY (REPEAT_EN=1) or HOLD (REPEAT_EN=0).
//   DELAY:  count REPEAT_DELAY cycles from grant; owner released -> IDLE, no pulse;
//           at expiry pulse move[owner], -> REPEAT.
//   REPEAT: pulse move[owner] every REPEAT_RATE cycles; owner released -> IDLE.
//   HOLD:   no pulses; owner released -> IDLE.
//  Release checked before expiry: release and expiry on the same cycle -> IDLE, no pulse.
//  enable=0: move forced 0 combinationally-free (registered 0 next edge), state -> IDLE,
//   repeat counter clears; debounce and key_held keep running.
//  Latency: raw KEY first sampled low (stable) -> key_held=1 after 2+DEBOUNCE_CYCLES edges;
//   move pulse on the following edge. move is registered; never more than one bit set.
//  Counters saturate-free: each clears on state entry; no wrap can occur with legal CNT_W.
// TESTING (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_EN=1)
//  KEY[3] low at cycle 0, held 8 cycles -> key_held[3]=1 at edge 6, move=4'b1000 at edge 7
//   only, busy=1 from edge 7; release -> busy=0 after debounce, no further pulses.
//  KEY[0] toggles low for 3 cycles, high 1, low 3 -> key_held stays 0, move never asserted.
//  KEY[0] held 40 cycles -> pulses at edges 7, 17, 20, 23, 26, ... (10 then every 3).
//  KEY[2] and KEY[1] pressed same cycle -> single pulse 4'b0100; holding KEY[1] after
//   releasing KEY[2] yields no pulse until KEY[1] released and re-pressed.
//  enable=0 during REPEAT -> no pulses, busy=0 next edge; enable=1 while key still held
//   -> no pulse (fresh cleared) until re-press.
//  reset=0 asserted mid-DELAY -> move, busy, key_held 0 immediately; after release with
//   KEY high, first press behaves as in scenario 1.

Source files
------------

// File: rtl/cursor_key_ctrl_if.sv
// Pushbutton/cursor bus: raw keys and enable in, move pulses and status out.
interface cursor_key_ctrl_if;
  logic [3:0] KEY;
  logic       enable;
  logic [3:0] move;
  logic [3:0] key_held;
  logic       busy;

  modport master (output KEY, output enable, input move, input key_held, input busy);
  modport slave  (input KEY, input enable, output move, output key_held, output busy);
endinterface

// File: rtl/cursor_key_ctrl.sv
// Cursor key conditioner: 2-flop sync, per-key debounce, priority grant of a
// freshly pressed key, one-cycle move pulses with optional hold-to-repeat.
module cursor_key_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned CNT_W           = 25
) (
  input logic              clock,
  input logic              reset,
  cursor_key_ctrl_if.slave ck
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} state_t;

  logic [3:0]       sync1_reg, sync2_reg;
  logic [3:0]       held, settle, held_next;
  logic [3:0]       fresh_reg, fresh_next;
  state_t           state_reg, state_next;
  logic [1:0]       owner_reg, owner_next;
  logic [CNT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic [3:0]       move_reg, move_next;
  logic             grant;

  // Highest-priority fresh key: left > up > down > right.
  function automatic logic [1:0] pick(input logic [3:0] f);
    if (f[3])      return 2'd3;
    else if (f[2]) return 2'd2;
    else if (f[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  // Two-flop synchroniser, inverted so that 1 means pressed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= ~ck.KEY;
      sync2_reg <= sync1_reg;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    logic [CNT_W-1:0] cnt_reg;
    logic             held_reg;
    logic             differ;

    assign differ     = sync2_reg[gi] ^ held_reg;
    assign settle[gi] = differ && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign held[gi]   = held_reg;

    // Debounce: count cycles of disagreement, adopt the new level once stable long enough.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_reg  <= '0;
        held_reg <= 1'b0;
      end else begin
        if (!differ || settle[gi]) cnt_reg <= '0;
        else                       cnt_reg <= cnt_reg + 1'b1;
        if (settle[gi]) held_reg <= sync2_reg[gi];
      end
    end
  end

  // Debounced level after this edge; fresh follows its edges and clears on grant/disable.
  assign held_next  = held ^ settle;
  assign fresh_next = (grant || !ck.enable) ? 4'b0000
                    : ((fresh_reg | (held_next & ~held)) & ~(held & ~held_next));

  // Sequencer next state: grant, delay/repeat timing, release and disable handling.
  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    rpt_cnt_next = rpt_cnt_reg + 1'b1;
    move_next    = 4'b0000;
    grant        = 1'b0;
    if (!ck.enable) begin
      state_next   = IDLE;
      rpt_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          rpt_cnt_next = '0;
          if (|fresh_reg) begin
            grant      = 1'b1;
            owner_next = pick(fresh_reg);
            move_next  = 4'b0001 << pick(fresh_reg);
            state_next = REPEAT_EN ? DELAY : HOLD;
          end
        end
        DELAY: begin
          if (!held[owner_reg]) begin
            state_next   = IDLE;
            rpt_cnt_next = '0;
          end else if (rpt_cnt_reg == CNT_W'(REPEAT_DELAY - 1)) begin
            move_next    = 4'b0001 << owner_reg;
            state_next   = REPEAT;
            rpt_cnt_next = '0;
          end
        end
        REPEAT: begin
          if (!held[owner_reg]) begin
            state_next   = IDLE;
            rpt_cnt_next = '0;
          end else if (rpt_cnt_reg == CNT_W'(REPEAT_RATE - 1)) begin
            move_next    = 4'b0001 << owner_reg;
            rpt_cnt_next = '0;
          end
        end
        HOLD: begin
          rpt_cnt_next = '0;
          if (!held[owner_reg]) state_next = IDLE;
        end
        default: begin
          state_next   = IDLE;
          rpt_cnt_next = '0;
        end
      endcase
    end
  end

  // Sequencer registers, fresh flags and the registered move pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      owner_reg   <= 2'd0;
      rpt_cnt_reg <= '0;
      move_reg    <= 4'b0000;
      fresh_reg   <= 4'b0000;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      rpt_cnt_reg <= rpt_cnt_next;
      move_reg    <= move_next;
      fresh_reg   <= fresh_next;
    end
  end

  assign ck.move     = move_reg;
  assign ck.key_held = held;
  assign ck.busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_cursor_key_ctrl.sv
// Bench for cursor_key_ctrl: timestamp-based reference model checked every
// cycle, plus directed scenarios with hand-computed pulse edges.
module tb_cursor_key_ctrl;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  cursor_key_ctrl_if ck();

  cursor_key_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .REPEAT_EN(1'b1), .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ck(ck)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: edges are numbered; a granted key pulses at grant,
  // grant+RD, then every RR edges while still held.
  int         edge_no = 0;
  logic [3:0] m_p1 = '0, m_p2 = '0, m_held = '0, m_fresh = '0, m_move = '0;
  logic       m_busy = 1'b0;
  int         m_owner = 0;
  int         m_grant_edge = 0;
  int         m_streak [4] = '{0, 0, 0, 0};

  always @(posedge clock or negedge reset) begin : model
    logic [3:0] sp, nh, nf, mv;
    logic       nb, granted;
    int         own, d, e;
    if (!reset) begin
      m_p1 <= '0; m_p2 <= '0; m_held <= '0; m_fresh <= '0; m_move <= '0;
      m_busy <= 1'b0; m_owner <= 0; m_grant_edge <= 0;
      for (int i = 0; i < 4; i++) m_streak[i] <= 0;
    end else begin
      e = edge_no + 1;
      edge_no <= e;
      sp = m_p2;
      m_p1 <= ~ck.KEY;
      m_p2 <= m_p1;
      nh = m_held;
      for (int i = 0; i < 4; i++) begin
        if (sp[i] != m_held[i]) begin
          if (m_streak[i] + 1 == DEB) begin
            nh[i] = sp[i];
            m_streak[i] <= 0;
          end else begin
            m_streak[i] <= m_streak[i] + 1;
          end
        end else begin
          m_streak[i] <= 0;
        end
      end
      nf = (m_fresh | (nh & ~m_held)) & ~(m_held & ~nh);
      mv = '0; nb = m_busy; granted = 1'b0; own = m_owner;
      if (!ck.enable) begin
        nb = 1'b0;
      end else if (m_busy) begin
        if (!m_held[m_owner]) nb = 1'b0;
        else begin
          d = e - m_grant_edge;
          if (d == RD || (d > RD && (d - RD) % RR == 0)) mv = 4'b0001 << m_owner;
        end
      end else if (m_fresh != 0) begin
        for (int i = 0; i < 4; i++) if (m_fresh[i]) own = i;
        granted = 1'b1;
        mv = 4'b0001 << own;
        nb = 1'b1;
        m_grant_edge <= e;
      end
      if (!ck.enable || granted) nf = '0;
      m_held <= nh; m_fresh <= nf; m_move <= mv; m_busy <= nb; m_owner <= own;
    end
  end

  // Compare process plus pulse log (edge number and value of every move pulse).
  int         pulse_edge[$];
  logic [3:0] pulse_val[$];

  always @(negedge clock) begin
    check("move", int'(ck.move), int'(m_move));
    check("key_held", int'(ck.key_held), int'(m_held));
    check("busy", int'(ck.busy), int'(m_busy));
    check("move_onehot", int'($countones(ck.move) <= 1), 1);
    if (reset && ck.move != 4'b0000) begin
      pulse_edge.push_back(edge_no);
      pulse_val.push_back(ck.move);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  int base, start;
  int exp_s3 [4] = '{7, 17, 20, 23};

  initial begin
    ck.KEY = 4'hF;
    ck.enable = 1'b1;
    #1 reset = 1'b0;
    @(negedge clock); #1;
    check("rst_move", int'(ck.move), 0);
    check("rst_held", int'(ck.key_held), 0);
    check("rst_busy", int'(ck.busy), 0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // Single press of left: held at edge 6, one pulse at edge 7, busy until release settles.
    base = edge_no; start = pulse_edge.size();
    ck.KEY = 4'b0111;
    tick(5); check("s1_held_e5", int'(ck.key_held), 0);
    tick(1); check("s1_held_e6", int'(ck.key_held), 8); check("s1_move_e6", int'(ck.move), 0);
    tick(1); check("s1_move_e7", int'(ck.move), 8); check("s1_busy_e7", int'(ck.busy), 1);
    tick(1); check("s1_move_e8", int'(ck.move), 0);
    ck.KEY = 4'hF;
    tick(6); check("s1_busy_e14", int'(ck.busy), 1);
    tick(1); check("s1_busy_e15", int'(ck.busy), 0);
    tick(10);
    check("s1_pulses", pulse_edge.size() - start, 1);
    check("s1_pulse_edge", pulse_edge[start] - base, 7);

    // Bouncing right key: 3 low, 1 high, 3 low never debounces.
    start = pulse_edge.size();
    ck.KEY = 4'b1110; tick(3);
    ck.KEY = 4'hF;    tick(1);
    ck.KEY = 4'b1110; tick(3);
    ck.KEY = 4'hF;    tick(2);
    check("s2_held", int'(ck.key_held), 0);
    tick(10);
    check("s2_pulses", pulse_edge.size() - start, 0);

    // Right held 40 cycles: pulses at 7, 17, then every 3 edges until release settles.
    base = edge_no; start = pulse_edge.size();
    ck.KEY = 4'b1110;
    tick(40);
    ck.KEY = 4'hF;
    tick(20);
    check("s3_pulses", pulse_edge.size() - start, 11);
    for (int k = 0; k < 4; k++) begin
      check("s3_edge", pulse_edge[start + k] - base, exp_s3[k]);
      check("s3_val", int'(pulse_val[start + k]), 1);
    end

    // Up and down together: up wins, down is discarded until re-pressed.
    base = edge_no; start = pulse_edge.size();
    ck.KEY = 4'b1001;
    tick(8);
    ck.KEY = 4'b1101;
    tick(30);
    ck.KEY = 4'hF;
    tick(12);
    check("s4_pulses", pulse_edge.size() - start, 1);
    check("s4_edge", pulse_edge[start] - base, 7);
    check("s4_val", int'(pulse_val[start]), 4);
    base = edge_no; start = pulse_edge.size();
    ck.KEY = 4'b1101;
    tick(7); check("s4_repress_move", int'(ck.move), 2);
    ck.KEY = 4'hF;
    tick(12);

    // Disable during repeat, re-enable with key still held: no further pulses.
    base = edge_no; start = pulse_edge.size();
    ck.KEY = 4'b0111;
    tick(18); check("s5_busy_e18", int'(ck.busy), 1);
    ck.enable = 1'b0;
    tick(1); check("s5_busy_e19", int'(ck.busy), 0);
    tick(5);
    ck.enable = 1'b1;
    tick(20);
    ck.KEY = 4'hF;
    tick(12);
    check("s5_pulses", pulse_edge.size() - start, 2);
    check("s5_edge2", pulse_edge[start + 1] - base, 17);

    // Reset asserted during the first pulse (DELAY entered) clears outputs at once.
    ck.KEY = 4'b1110;
    tick(7); check("s6_move_e7", int'(ck.move), 1);
    #1 reset = 1'b0;
    #1;
    check("s6_rst_move", int'(ck.move), 0);
    check("s6_rst_busy", int'(ck.busy), 0);
    check("s6_rst_held", int'(ck.key_held), 0);
    ck.KEY = 4'hF;
    tick(3);
    reset = 1'b1;
    tick(2);
    base = edge_no;
    ck.KEY = 4'b0111;
    tick(6); check("s6_held_e6", int'(ck.key_held), 8);
    tick(1); check("s6_move_e7", int'(ck.move), 8);
    ck.KEY = 4'hF;
    tick(15);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
